dbus_sram_ctrl: RTL and testbench
=================================

Name: dbus_sram_ctrl

Overview:
- Bus slave that sits directly downstream of the core's data-bus master port and turns each bus transaction into a single-port synchronous SRAM access.
- Handles byte/half/word sizing: lane shifting, byte enables, and right-aligned read data, so the core sign/zero-extends from bit 0.
- Decodes its own address window and flags misaligned or out-of-window accesses with an error response.
- Configurable wait states model slower memories.

Parameters:
- BASE_ADDR, 32'h0001_0000, byte address of word 0 of the SRAM window.
- DEPTH_WORDS, 1024, SRAM depth in 32-bit words; power of two.
- WAIT_STATES, 0, extra idle cycles inserted before the SRAM access (0..15).
- AW, $clog2(DEPTH_WORDS), SRAM word-address width (derived).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- breq  in  1  master requests bus; ignored by this block, present for interface completeness.
- bstart  in  1  transaction request; master holds it high until it samples bdone.
- ttype  in  1  0=READ, 1=WRITE.
- tsize  in  2  0=BYTE, 1=HALF, 2=WORD, 3=reserved.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  out  32  load data, right-aligned, zero above access size.
- bdone  out  1  one-cycle completion pulse.
- berror  out  1  valid with bdone; 1 = access rejected.
- sram_en  out  1  SRAM chip enable.
- sram_we  out  1  SRAM write enable, qualified by sram_en.
- sram_be  out  4  SRAM byte enables.
- sram_addr  out  AW  SRAM word address.
- sram_wdata  out  32  lane-shifted write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after an enabled read.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; bdone, berror, sram_en, sram_we = 0; sram_be=0; rdata=0; wait counter=0; all latched request fields cleared.
  - Reset mid-transaction aborts it: no bdone, and no SRAM write after the reset edge.
- FSM states: IDLE, WAIT, MEM, RESP.
- IDLE:
  - If bstart=1, latch addr, ttype, tsize, wdata.
  - If the latched request is legal, go to WAIT (WAIT_STATES>0, counter loaded with WAIT_STATES-1) or MEM (WAIT_STATES=0).
  - If illegal, go to RESP with error flag set.
- WAIT: count down; at 0 go to MEM.
- MEM:
  - sram_en=1; sram_we=ttype; sram_addr=(addr-BASE_ADDR)[AW+1:2].
  - sram_be: BYTE = 4'b0001<<addr[1:0]; HALF = 4'b0011<<addr[1:0]; WORD = 4'b1111.
  - sram_wdata=wdata<<(8*addr[1:0]).
  - Next state RESP.
- RESP:
  - bdone=1 for exactly one cycle.
  - Read: rdata=(sram_rdata>>(8*addr[1:0])) masked to 8/16/32 bits.
  - Write or error: rdata=0.
  - berror = error flag.
  - Next state IDLE. bstart is not sampled in RESP, so a held bstart is never double-accepted.
- Latency: acceptance edge to bdone = WAIT_STATES+2 cycles for legal accesses; errors give bdone the cycle after acceptance.
- Back-to-back: bstart high in the IDLE cycle after RESP starts a new transaction; minimum issue interval is WAIT_STATES+3 cycles.
- Legality (all must hold):
  - BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS, with unsigned 32-bit compare (no wrap at 2^32).
  - tsize != 3.
  - HALF requires addr[0]=0; WORD requires addr[1:0]=0.
- Illegal accesses never assert sram_en.
- Inputs other than bstart are don't-care outside IDLE; latched copies are used throughout.
- sram_en and sram_we are 0 in every state except MEM.
- rdata holds its last value outside RESP.

Test Plan:
- Reset then word write: addr=0x0001_0004, wdata=0xDEADBEEF, WAIT_STATES=0 → sram_be=4'b1111, sram_addr=1 in MEM; bdone 2 cycles after acceptance; berror=0.
- Byte read: SRAM word 1 holds 0xDEADBEEF, read BYTE at 0x0001_0006 → sram_be=4'b0100; rdata=0x000000AD.
- Half write at 0x0001_0002, wdata=0x1234ABCD → sram_be=4'b1100, sram_wdata[31:16]=0xABCD; a subsequent WORD read of 0x0001_0000 returns 0xABCDxxxx with the low half unchanged.
- Errors:
  - HALF read at 0x0001_0001 → bdone+berror one cycle after acceptance, rdata=0, sram_en never 1.
  - Same response for addr=0x0000_FFFC and for tsize=3.
- WAIT_STATES=3 with bstart held high continuously across two reads → each bdone arrives 5 cycles after acceptance, exactly one bdone per transaction, and the second acceptance occurs in the cycle after the first RESP.
- rst_n=0 during the WAIT cycle of a write → no sram_en/sram_we pulse follows, no bdone, all outputs 0; the next request completes normally.

Source files
------------

// File: rtl/dbus_sram_ctrl.sv
// Data-bus slave turning one bus transaction into one single-port synchronous SRAM access.
// Latency: bdone WAIT_STATES+2 cycles after acceptance (1 cycle for rejected accesses).
// Backpressure: one transaction in flight; bstart is only sampled in IDLE, so a held request is never double-accepted.
module dbus_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0,
  parameter int          AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          breq,
  input  logic          bstart,
  input  logic          ttype,
  input  logic [1:0]    tsize,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          bdone,
  output logic          berror,
  output logic          sram_en,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // One past the last byte of the window, widened to 33 bits so the compare never wraps.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  logic [1:0]  state;
  logic [3:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ttype_q;
  logic [1:0]  tsize_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        in_window;
  logic        aligned;
  logic        legal;
  logic [31:0] rd_shift;
  logic [31:0] rdata_resp;
  logic [3:0]  be_calc;
  logic [31:0] addr_off;
  logic        mem_phase;
  logic        unused_bits;

  // Legality of the request presented in IDLE: inside the window, defined size, naturally aligned.
  always_comb begin
    in_window = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < LIMIT);
    case (tsize)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~addr[0];
      2'd2:    aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    legal = in_window && aligned;
  end

  // Read data right-aligned and masked to the access size; writes and rejects return zero.
  always_comb begin
    rd_shift = sram_rdata >> {addr_q[1:0], 3'b000};
    case (tsize_q)
      2'd0:    rdata_resp = {24'd0, rd_shift[7:0]};
      2'd1:    rdata_resp = {16'd0, rd_shift[15:0]};
      default: rdata_resp = rd_shift;
    endcase
    if (ttype_q || err_q) begin
      rdata_resp = 32'd0;
    end
  end

  // Byte-lane enables for the latched size and offset.
  always_comb begin
    case (tsize_q)
      2'd0:    be_calc = 4'b0001 << addr_q[1:0];
      2'd1:    be_calc = 4'b0011 << addr_q[1:0];
      default: be_calc = 4'b1111;
    endcase
  end

  // Transaction sequencer: accept in IDLE, optional wait countdown, one SRAM cycle, one response cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      ttype_q  <= 1'b0;
      tsize_q  <= 2'd0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bstart) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            ttype_q <= ttype;
            tsize_q <= tsize;
            err_q   <= ~legal;
            if (!legal) begin
              state <= S_RESP;
            end else if (WAIT_STATES > 0) begin
              state    <= S_WAIT;
              wait_cnt <= 4'(WAIT_STATES - 1);
            end else begin
              state <= S_MEM;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_MEM;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_MEM: begin
          state <= S_RESP;
        end
        S_RESP: begin
          state   <= S_IDLE;
          rdata_q <= rdata_resp;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // SRAM strobes exist only in MEM; everything else is quiet so the bus looks idle after reset.
  always_comb begin
    mem_phase  = (state == S_MEM);
    addr_off   = addr_q - BASE_ADDR;
    sram_en    = mem_phase;
    sram_we    = mem_phase & ttype_q;
    sram_be    = mem_phase ? be_calc : 4'd0;
    sram_addr  = mem_phase ? addr_off[AW+1:2] : '0;
    sram_wdata = mem_phase ? (wdata_q << {addr_q[1:0], 3'b000}) : 32'd0;
    bdone      = (state == S_RESP);
    berror     = bdone & err_q;
    rdata      = bdone ? rdata_resp : rdata_q;
  end

  // breq and the out-of-window offset bits carry no information for this slave.
  assign unused_bits = ^{breq, addr_off[31:AW+2], addr_off[1:0]};

endmodule

// File: tb/tb_dbus_sram_ctrl.sv
// Bench for dbus_sram_ctrl: two instances (no wait states, three wait states) each on a behavioural SRAM.
// Random and directed bus transactions are checked against a byte-array reference of the memory window.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_dbus_sram_ctrl;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 1024;
  localparam int          AW    = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic breq = 1'b0;
  always #5 clk = ~clk;

  logic          bstart0, ttype0, bdone0, berror0, sram_en0, sram_we0;
  logic [1:0]    tsize0;
  logic [31:0]   addr0, wdata0, rdata0, sram_wdata0, sram_rdata0;
  logic [3:0]    sram_be0;
  logic [AW-1:0] sram_addr0;
  logic          bstart3, ttype3, bdone3, berror3, sram_en3, sram_we3;
  logic [1:0]    tsize3;
  logic [31:0]   addr3, wdata3, rdata3, sram_wdata3, sram_rdata3;
  logic [3:0]    sram_be3;
  logic [AW-1:0] sram_addr3;

  dbus_sram_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .breq(breq), .bstart(bstart0), .ttype(ttype0), .tsize(tsize0),
    .addr(addr0), .wdata(wdata0), .rdata(rdata0), .bdone(bdone0), .berror(berror0),
    .sram_en(sram_en0), .sram_we(sram_we0), .sram_be(sram_be0), .sram_addr(sram_addr0),
    .sram_wdata(sram_wdata0), .sram_rdata(sram_rdata0));

  dbus_sram_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .breq(breq), .bstart(bstart3), .ttype(ttype3), .tsize(tsize3),
    .addr(addr3), .wdata(wdata3), .rdata(rdata3), .bdone(bdone3), .berror(berror3),
    .sram_en(sram_en3), .sram_we(sram_we3), .sram_be(sram_be3), .sram_addr(sram_addr3),
    .sram_wdata(sram_wdata3), .sram_rdata(sram_rdata3));

  // Behavioural SRAMs plus a clear strobe and a backdoor word write for preloading.
  logic [31:0] mem0 [0:DEPTH-1];
  logic [31:0] mem3 [0:DEPTH-1];
  logic        mem_clr = 1'b1;
  logic        bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0] bd_data = 32'd0;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem0[i] <= 32'd0;
        mem3[i] <= 32'd0;
      end
    end else begin
      if (sram_en0) begin
        if (sram_we0) begin
          for (int b = 0; b < 4; b++) if (sram_be0[b]) mem0[sram_addr0][8*b +: 8] <= sram_wdata0[8*b +: 8];
        end else sram_rdata0 <= mem0[sram_addr0];
      end
      if (sram_en3) begin
        if (sram_we3) begin
          for (int b = 0; b < 4; b++) if (sram_be3[b]) mem3[sram_addr3][8*b +: 8] <= sram_wdata3[8*b +: 8];
        end else sram_rdata3 <= mem3[sram_addr3];
      end
      if (bd_we) mem3[bd_addr] <= bd_data;
    end
  end

  // Observation mux: the transaction task watches whichever instance it drives.
  logic sel3 = 1'b0;
  logic        cur_bdone, cur_berror, cur_en, cur_we;
  logic [31:0] cur_rdata, cur_wdata;
  logic [3:0]  cur_be;
  logic [AW-1:0] cur_addr;
  assign cur_bdone  = sel3 ? bdone3 : bdone0;
  assign cur_berror = sel3 ? berror3 : berror0;
  assign cur_en     = sel3 ? sram_en3 : sram_en0;
  assign cur_we     = sel3 ? sram_we3 : sram_we0;
  assign cur_rdata  = sel3 ? rdata3 : rdata0;
  assign cur_wdata  = sel3 ? sram_wdata3 : sram_wdata0;
  assign cur_be     = sel3 ? sram_be3 : sram_be0;
  assign cur_addr   = sel3 ? sram_addr3 : sram_addr0;

  int checks = 0;
  int errors = 0;

  // Reference: the memory window as bytes, relative to BASE.
  logic [7:0] refm [0:4*DEPTH-1];

  function automatic void ref_access(input logic tt, input logic [1:0] sz, input logic [31:0] a,
                                     input logic [31:0] wd, output bit legal, output logic [31:0] exp_rd,
                                     output logic [3:0] exp_be, output logic [31:0] exp_wd);
    longint la  = longint'(a);
    longint lb  = longint'(BASE);
    int     nb  = 1 << sz;
    int     off = int'(a[1:0]);
    legal  = (sz != 2'd3) && (la >= lb) && (la < lb + 4 * DEPTH) && ((off % nb) == 0);
    exp_rd = 32'd0;
    exp_be = 4'd0;
    exp_wd = 32'd0;
    if (legal) begin
      for (int i = 0; i < nb; i++) begin
        int idx = int'(la - lb) + i;
        exp_be[off + i] = 1'b1;
        exp_wd[8*(off + i) +: 8] = wd[8*i +: 8];
        if (tt) refm[idx] = wd[8*i +: 8];
        else    exp_rd[8*i +: 8] = refm[idx];
      end
    end
  endfunction

  // Issue one request, hold bstart until bdone, record what the SRAM side and response looked like.
  task automatic run_txn(input bit w3, input logic tt, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat,
                         output int en_cnt, output int we_cnt, output logic [3:0] be_s,
                         output logic [AW-1:0] ad_s, output logic [31:0] wd_s,
                         output logic [31:0] rd_after, output logic done_after);
    bit done = 0;
    @(negedge clk);
    sel3 = w3;
    if (w3) begin ttype3 = tt; tsize3 = sz; addr3 = a; wdata3 = wd; bstart3 = 1'b1; end
    else    begin ttype0 = tt; tsize0 = sz; addr0 = a; wdata0 = wd; bstart0 = 1'b1; end
    rd = 32'd0; er = 1'b0; lat = 0; en_cnt = 0; we_cnt = 0; be_s = 4'd0; ad_s = '0; wd_s = 32'd0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (cur_en) begin en_cnt++; be_s = cur_be; ad_s = cur_addr; wd_s = cur_wdata; end
      if (cur_we) we_cnt++;
      if (cur_bdone) begin
        done = 1; rd = cur_rdata; er = cur_berror;
        bstart0 = 1'b0; bstart3 = 1'b0;
      end
    end
    if (!done) begin lat = -1; bstart0 = 1'b0; bstart3 = 1'b0; end
    @(negedge clk);
    rd_after = cur_rdata;
    done_after = cur_bdone;
  endtask

  logic [31:0] rd, wd_s, rd_after, exp_rd, exp_wd;
  logic [3:0]  be_s, exp_be;
  logic [AW-1:0] ad_s;
  logic        er, done_after;
  bit          legal;
  int          lat, en_cnt, we_cnt;

  task automatic test_reset();
    rst_n = 1'b0; mem_clr = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; mem_clr = 1'b0;
    @(negedge clk);
    checks++; if (bdone0 !== 1'b0 || berror0 !== 1'b0) begin errors++; $display("FAIL reset_done: bdone=%b berror=%b want 0 0", bdone0, berror0); end
    checks++; if (sram_en0 !== 1'b0 || sram_we0 !== 1'b0) begin errors++; $display("FAIL reset_en: en=%b we=%b want 0 0", sram_en0, sram_we0); end
    checks++; if (sram_be0 !== 4'd0) begin errors++; $display("FAIL reset_be: got %b want 0000", sram_be0); end
    checks++; if (rdata0 !== 32'd0 || rdata3 !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0", rdata0, rdata3); end
  endtask

  task automatic test_sizing();
    ref_access(1'b1, 2'd2, 32'h0001_0004, 32'hDEADBEEF, legal, exp_rd, exp_be, exp_wd);
    run_txn(0, 1'b1, 2'd2, 32'h0001_0004, 32'hDEADBEEF, rd, er, lat, en_cnt, we_cnt, be_s, ad_s, wd_s, rd_after, done_after);
    checks++; if (lat !== 2) begin errors++; $display("FAIL word_wr_lat: got %0d want 2", lat); end
    checks++; if (be_s !== 4'b1111 || ad_s !== 10'd1) begin errors++; $display("FAIL word_wr_be_addr: be=%b addr=%0d want 1111 1", be_s, ad_s); end
    checks++; if (er !== 1'b0 || we_cnt !== 1 || en_cnt !== 1) begin errors++; $display("FAIL word_wr_resp: err=%b we=%0d en=%0d want 0 1 1", er, we_cnt, en_cnt); end
    checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL word_wr_pulse: bdone still %b", done_after); end
    ref_access(1'b0, 2'd0, 32'h0001_0006, 32'd0, legal, exp_rd, exp_be, exp_wd);
    run_txn(0, 1'b0, 2'd0, 32'h0001_0006, 32'd0, rd, er, lat, en_cnt, we_cnt, be_s, ad_s, wd_s, rd_after, done_after);
    checks++; if (be_s !== 4'b0100) begin errors++; $display("FAIL byte_rd_be: got %b want 0100", be_s); end
    checks++; if (rd !== 32'h0000_00AD || rd_after !== 32'h0000_00AD) begin errors++; $display("FAIL byte_rd_data: got %h hold %h want 000000ad", rd, rd_after); end
    ref_access(1'b1, 2'd1, 32'h0001_0002, 32'h1234ABCD, legal, exp_rd, exp_be, exp_wd);
    run_txn(0, 1'b1, 2'd1, 32'h0001_0002, 32'h1234ABCD, rd, er, lat, en_cnt, we_cnt, be_s, ad_s, wd_s, rd_after, done_after);
    checks++; if (be_s !== 4'b1100 || wd_s[31:16] !== 16'hABCD) begin errors++; $display("FAIL half_wr: be=%b wdata_hi=%h want 1100 abcd", be_s, wd_s[31:16]); end
    ref_access(1'b0, 2'd2, 32'h0001_0000, 32'd0, legal, exp_rd, exp_be, exp_wd);
    run_txn(0, 1'b0, 2'd2, 32'h0001_0000, 32'd0, rd, er, lat, en_cnt, we_cnt, be_s, ad_s, wd_s, rd_after, done_after);
    checks++; if (rd !== 32'hABCD_0000) begin errors++; $display("FAIL half_wr_readback: got %h want abcd0000", rd); end
  endtask

  task automatic test_errors();
    logic       t_tt [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0] t_sz [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
    logic [31:0] t_a [4] = '{32'h0001_0001, 32'h0000_FFFC, 32'h0001_0000, 32'h0001_1000};
    for (int k = 0; k < 4; k++) begin
      run_txn(0, t_tt[k], t_sz[k], t_a[k], 32'hFFFF_FFFF, rd, er, lat, en_cnt, we_cnt, be_s, ad_s, wd_s, rd_after, done_after);
      checks++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || en_cnt !== 0) begin
        errors++; $display("FAIL err_case%0d: lat=%0d err=%b rdata=%h en=%0d want 1 1 0 0", k, lat, er, rd, en_cnt);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, wd;
      logic [1:0]  sz;
      logic        tt;
      int          r = int'($urandom_range(0, 9));
      if (r == 0)      a = $urandom;
      else if (r == 1) a = BASE + 32'(4 * DEPTH) - 32'd4 + 32'($urandom_range(0, 7));
      else if (r == 2) a = BASE - 32'd1 - 32'($urandom_range(0, 3));
      else             a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      sz = 2'($urandom_range(0, 3));
      tt = 1'($urandom_range(0, 1));
      wd = $urandom;
      ref_access(tt, sz, a, wd, legal, exp_rd, exp_be, exp_wd);
      run_txn(0, tt, sz, a, wd, rd, er, lat, en_cnt, we_cnt, be_s, ad_s, wd_s, rd_after, done_after);
      checks++;
      if (er !== !legal || lat !== (legal ? 2 : 1) || en_cnt !== (legal ? 1 : 0) || we_cnt !== ((legal && tt) ? 1 : 0)) begin
        errors++; $display("FAIL rand%0d_ctrl: a=%h sz=%0d wr=%b err=%b lat=%0d en=%0d we=%0d", n, a, sz, tt, er, lat, en_cnt, we_cnt);
      end
      checks++;
      if (rd !== exp_rd || rd_after !== exp_rd || done_after !== 1'b0) begin
        errors++; $display("FAIL rand%0d_rdata: a=%h sz=%0d got %h hold %h want %h", n, a, sz, rd, rd_after, exp_rd);
      end
      if (legal) begin
        logic [31:0] lane_mask = {{8{exp_be[3]}}, {8{exp_be[2]}}, {8{exp_be[1]}}, {8{exp_be[0]}}};
        checks++;
        if (be_s !== exp_be || ad_s !== AW'((a - BASE) >> 2) || (tt && ((wd_s & lane_mask) !== exp_wd))) begin
          errors++; $display("FAIL rand%0d_sram: a=%h be=%b want %b addr=%0d wdata=%h want %h", n, a, be_s, exp_be, ad_s, wd_s & lane_mask, exp_wd);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0, dones = 0, ens = 0, first = -1, second = -1;
    @(negedge clk);
    bd_we = 1'b1; bd_addr = 10'd5; bd_data = 32'hCAFE_F00D;
    @(negedge clk);
    bd_we = 1'b0;
    ttype3 = 1'b0; tsize3 = 2'd2; addr3 = BASE + 32'd20; bstart3 = 1'b1;
    while (n < 40 && dones < 2) begin
      @(negedge clk);
      n++;
      if (sram_en3) ens++;
      if (bdone3) begin
        dones++;
        if (dones == 1) first = n; else second = n;
        checks++; if (rdata3 !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_rdata%0d: got %h want cafef00d", dones, rdata3); end
      end
    end
    bstart3 = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bdone3) dones++;
      if (sram_en3) ens++;
    end
    checks++; if (first !== 5) begin errors++; $display("FAIL b2b_first_lat: got %0d want 5", first); end
    checks++; if (second !== 11) begin errors++; $display("FAIL b2b_second_at: got %0d want 11", second); end
    checks++; if (dones !== 2 || ens !== 2) begin errors++; $display("FAIL b2b_count: bdone=%0d en=%0d want 2 2", dones, ens); end
  endtask

  task automatic test_reset_mid();
    int ens = 0, dones = 0;
    @(negedge clk);
    ttype3 = 1'b1; tsize3 = 2'd2; addr3 = BASE + 32'd24; wdata3 = 32'h1122_3344; bstart3 = 1'b1;
    @(negedge clk);
    bstart3 = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (bdone3 !== 1'b0 || berror3 !== 1'b0 || sram_en3 !== 1'b0 || sram_we3 !== 1'b0 || sram_be3 !== 4'd0 ||
        sram_addr3 !== '0 || sram_wdata3 !== 32'd0 || rdata3 !== 32'd0) begin
      errors++; $display("FAIL midrst_outputs: done=%b err=%b en=%b we=%b be=%b rdata=%h want all 0", bdone3, berror3, sram_en3, sram_we3, sram_be3, rdata3);
    end
    repeat (10) begin
      @(negedge clk);
      if (sram_en3 || sram_we3) ens++;
      if (bdone3) dones++;
    end
    checks++; if (ens !== 0 || dones !== 0 || mem3[6] !== 32'd0) begin errors++; $display("FAIL midrst_aborted: en=%0d bdone=%0d mem=%h want 0 0 0", ens, dones, mem3[6]); end
    run_txn(1, 1'b0, 2'd2, BASE + 32'd20, 32'd0, rd, er, lat, en_cnt, we_cnt, be_s, ad_s, wd_s, rd_after, done_after);
    checks++; if (lat !== 5 || er !== 1'b0 || rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL midrst_next: lat=%0d err=%b rdata=%h want 5 0 cafef00d", lat, er, rd); end
  endtask

  initial begin
    bstart0 = 1'b0; ttype0 = 1'b0; tsize0 = 2'd0; addr0 = 32'd0; wdata0 = 32'd0;
    bstart3 = 1'b0; ttype3 = 1'b0; tsize3 = 2'd0; addr3 = 32'd0; wdata3 = 32'd0;
    for (int i = 0; i < 4 * DEPTH; i++) refm[i] = 8'd0;
    test_reset();
    test_sizing();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
